axi_burst_splitter: RTL and testbench
=====================================

# axi_burst_splitter

Sequential command splitter between the user command FIFO and the AXI address channel (AW or AR) of the burst master. It accepts one user transfer of up to 2^CMD_LEN_W beats and emits a series of AXI-legal bursts. Each burst is capped at MAX_BURST_BEATS and optionally split at PAGE_SIZE_BYTES boundaries. An outstanding-burst credit counter throttles issue until completions return.

## Interface
- ADDR_W, 64, address width
- LEN_W, 8, AXI AxLEN width; bursts ≤ 2^LEN_W beats
- CMD_LEN_W, 16, user command length width (beats−1)
- ID_W, 4, transaction ID width
- PAGE_SIZE_BYTES, 4096, power of two; boundary not crossed when splitting enabled
- MAX_OUTSTANDING, 2, bursts issued but not completed; ≥1
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in/out  1  user command handshake
- cmd_addr  in  ADDR_W  start byte address
- cmd_len  in  CMD_LEN_W  total beats − 1
- cmd_size  in  3  bytes/beat = 2^cmd_size; ≤ log2(DATA_W/8)
- cmd_id  in  ID_W  copied to every burst
- bst_valid / bst_ready  out/in  1  AXI address-channel handshake
- bst_addr  out  ADDR_W  burst start address
- bst_len  out  LEN_W  AxLEN (beats − 1)
- bst_size  out  3  AxSIZE
- bst_id  out  ID_W  AxID
- bst_last  out  1  final burst of the current command
- resp_done  in  1  one-cycle pulse per completed burst (B or final R)
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current credit count
- busy  out  1  command in progress (state ≠ IDLE)

## Operation
- FSM with states IDLE, CALC, and ISSUE.
- IDLE: cmd_ready=1. On handshake, latch addr, remaining=cmd_len+1, size, and id. Go to CALC.
- CALC: compute the burst using registered values.
  - base = addr with the low cmd_size bits cleared (a misaligned first beat is counted as a whole beat).
  - page_beats = (PAGE_SIZE_BYTES − base mod PAGE_SIZE_BYTES) >> size.
  - beats = min(remaining, page_beats, 2^LEN_W).
  - Register bst_len=beats−1 and bst_last=(beats==remaining).
  - Go to ISSUE only if outstanding < MAX_OUTSTANDING; otherwise stay in CALC.
- ISSUE: bst_valid=1. On bst_ready:
  - addr ← base + (beats << size)
  - remaining ← remaining − beats
  - outstanding increments.
  - Go to IDLE if bst_last=1, else CALC.
- Credit counter behaviour:
  - resp_done alone decrements.
  - Issue and resp_done in the same cycle leaves the count unchanged.
  - resp_done with outstanding==0 is ignored (count saturates at 0). This is a simulation assertion failure.
- Address arithmetic is ADDR_W wide and wraps modulo 2^ADDR_W. The remaining counter is CMD_LEN_W+1 bits wide.

## Timing
- Reset values:
  - cmd_ready=0 while aresetn=0, and 1 in IDLE after release.
  - bst_valid=0; bst_addr/len/size/id/last=0; outstanding=0; busy=0; state=IDLE.
- Latency: command handshake at edge N gives bst_valid at N+2 when credit is available.
- Throughput: one burst per 2 cycles (CALC+ISSUE).
- While bst_valid=1 and bst_ready=0, all bst_* outputs hold stable. bst_valid never drops without a handshake.
- Credit is checked only in CALC, so a granted ISSUE is never withdrawn.
- Reset asserted mid-command aborts it immediately. No partial state survives, and outstanding clears to 0.

## Configuration
- AXI_BURST_SPLIT_PAGE_EN defined: page_beats limits bursts as described above.
- AXI_BURST_SPLIT_PAGE_EN undefined: page_beats term removed. Bursts are capped by 2^LEN_W only, and the caller guarantees the 4 KB rule.

## Structure
- Shared package axi_master_pkg gains:
  - MAX_OUTSTANDING and CMD_LEN_W
  - typedef enum splitter_state_t {IDLE, CALC, ISSUE}
  - typedef struct burst_cmd_t {addr, len, size, id, last}
- One sub-module is natural: axi_credit_counter (up/down saturating counter with full flag), reused later for the R and W paths.

## Test plan
Defaults: PAGE_SIZE_BYTES=4096, size=4 (16 B/beat).
- Single burst: addr 0x1000, cmd_len 15 -> one burst 0x1000, len 15, last=1.
- Page split: addr 0x0FC0, cmd_len 15 -> 0x0FC0 len 3, then 0x1000 len 11 last=1. With the macro undefined: 0x0FC0 len 15 last=1.
- Long command: addr 0x0, cmd_len 599 -> 0x0 len 255, 0x1000 len 255, 0x2000 len 87 last=1.
- Credit stall: MAX_OUTSTANDING=2, resp_done held low during the long command -> third burst not valid. A resp_done pulse gives bst_valid two cycles later; outstanding reads 2,1,2.
- Backpressure plus simultaneous events: bst_ready low for 5 cycles -> outputs stable. A handshake in the same cycle as resp_done leaves outstanding unchanged.
- Reset mid-command: aresetn low during ISSUE -> all outputs 0 asynchronously. After release, a new command at addr 0x2000 with cmd_len 0 gives a single burst with len 0.

Source files
------------

// File: rtl/axi_master_pkg.sv
// Shared types and defaults for the AXI burst master.
// Used by the burst splitter and the credit counters.
package axi_master_pkg;

    localparam int AXI_ADDR_W      = 64;
    localparam int AXI_LEN_W       = 8;
    localparam int AXI_ID_W        = 4;
    localparam int CMD_LEN_W       = 16;
    localparam int MAX_OUTSTANDING = 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE
    } splitter_state_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
        logic [2:0]            size;
        logic [AXI_ID_W-1:0]   id;
        logic                  last;
    } burst_cmd_t;

endpackage

// File: rtl/axi_credit_counter.sv
// Up/down saturating counter with full flag.
// Tracks bursts issued but not yet completed.
module axi_credit_counter #(
    parameter int MAX = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inc_i,
    input  logic                         dec_i,
    output logic [$clog2(MAX+1)-1:0]     count_o,
    output logic                         full_o
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] count_q, count_d;
    logic         inc_ok, dec_ok;

    always_comb begin
        inc_ok  = inc_i && (count_q != W'(MAX));
        dec_ok  = dec_i && (count_q != '0);
        count_d = count_q;
        if (inc_ok && !dec_ok) begin
            count_d = count_q + W'(1);
        end else if (dec_ok && !inc_ok) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A completion with nothing outstanding means the response path is broken.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(dec_i && count_q == '0));
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == W'(MAX));

endmodule

// File: rtl/axi_burst_splitter.sv
// Splits user transfers into AXI-legal bursts with credit throttling.
// Define AXI_BURST_SPLIT_PAGE_EN to also split at PAGE_SIZE_BYTES boundaries.
module axi_burst_splitter
    import axi_master_pkg::*;
#(
    parameter int ADDR_W          = AXI_ADDR_W,
    parameter int LEN_W           = AXI_LEN_W,
    parameter int CMD_LEN_W       = axi_master_pkg::CMD_LEN_W,
    parameter int ID_W            = AXI_ID_W,
    parameter int PAGE_SIZE_BYTES = 4096,
    parameter int MAX_OUTSTANDING = axi_master_pkg::MAX_OUTSTANDING
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic [ADDR_W-1:0]                      cmd_addr,
    input  logic [CMD_LEN_W-1:0]                   cmd_len,
    input  logic [2:0]                             cmd_size,
    input  logic [ID_W-1:0]                        cmd_id,
    output logic                                   bst_valid,
    input  logic                                   bst_ready,
    output logic [ADDR_W-1:0]                      bst_addr,
    output logic [LEN_W-1:0]                       bst_len,
    output logic [2:0]                             bst_size,
    output logic [ID_W-1:0]                        bst_id,
    output logic                                   bst_last,
    input  logic                                   resp_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   busy
);

    localparam int REM_W = CMD_LEN_W + 1;

    splitter_state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [2:0]        size_q, size_d;
    logic [ID_W-1:0]   id_q, id_d;
    burst_cmd_t        bst_q, bst_d;

    logic [ADDR_W-1:0] size_mask;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] rem_ext;
    logic [ADDR_W-1:0] beats;
    logic [ADDR_W-1:0] beats_m1;
    logic [ADDR_W-1:0] sent_beats;
    logic              idle_rdy;
    logic              issue;
    logic              full;
`ifdef AXI_BURST_SPLIT_PAGE_EN
    logic [ADDR_W-1:0] page_beats;
`endif

    // Burst sizing works on the registered command so CALC is one flat cycle.
    always_comb begin
        size_mask = (ADDR_W'(1) << size_q) - ADDR_W'(1);
        base      = addr_q & ~size_mask;
        rem_ext   = ADDR_W'(rem_q);
        beats     = rem_ext;
        if ((ADDR_W'(1) << LEN_W) < beats) begin
            beats = ADDR_W'(1) << LEN_W;
        end
`ifdef AXI_BURST_SPLIT_PAGE_EN
        page_beats = (ADDR_W'(PAGE_SIZE_BYTES)
                      - (base & ADDR_W'(PAGE_SIZE_BYTES - 1))) >> size_q;
        if (page_beats < beats) begin
            beats = page_beats;
        end
`endif
        beats_m1   = beats - ADDR_W'(1);
        sent_beats = ADDR_W'(bst_q.len) + ADDR_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        size_d    = size_q;
        id_d      = id_q;
        bst_d     = bst_q;
        idle_rdy  = 1'b0;
        bst_valid = 1'b0;
        issue     = 1'b0;
        unique case (state_q)
            IDLE: begin
                idle_rdy = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = REM_W'(cmd_len) + REM_W'(1);
                    size_d  = cmd_size;
                    id_d    = cmd_id;
                    state_d = CALC;
                end
            end
            CALC: begin
                bst_d.addr = AXI_ADDR_W'(base);
                bst_d.len  = AXI_LEN_W'(beats_m1);
                bst_d.size = size_q;
                bst_d.id   = AXI_ID_W'(id_q);
                bst_d.last = (beats == rem_ext);
                if (!full) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bst_valid = 1'b1;
                if (bst_ready) begin
                    issue   = 1'b1;
                    addr_d  = ADDR_W'(bst_q.addr) + (sent_beats << size_q);
                    rem_d   = rem_q - REM_W'(sent_beats);
                    state_d = bst_q.last ? IDLE : CALC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            size_q  <= '0;
            id_q    <= '0;
            bst_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            size_q  <= size_d;
            id_q    <= id_d;
            bst_q   <= bst_d;
        end
    end

    axi_credit_counter #(
        .MAX(MAX_OUTSTANDING)
    ) u_credit (
        .clk    (aclk),
        .rst_n  (aresetn),
        .inc_i  (issue),
        .dec_i  (resp_done),
        .count_o(outstanding),
        .full_o (full)
    );

    assign cmd_ready = idle_rdy & aresetn;
    assign busy      = (state_q != IDLE);
    assign bst_addr  = ADDR_W'(bst_q.addr);
    assign bst_len   = LEN_W'(bst_q.len);
    assign bst_size  = bst_q.size;
    assign bst_id    = ID_W'(bst_q.id);
    assign bst_last  = bst_q.last;

endmodule

// File: tb/tb_axi_burst_splitter.sv
// Directed bench for axi_burst_splitter: vector table plus
// hand sequences for credit stall, backpressure and reset.
module tb_axi_burst_splitter;

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [2:0]  cmd_size;
    logic [3:0]  cmd_id;
    logic        bst_valid;
    logic        bst_ready;
    logic [63:0] bst_addr;
    logic [7:0]  bst_len;
    logic [2:0]  bst_size;
    logic [3:0]  bst_id;
    logic        bst_last;
    logic        resp_done;
    logic [1:0]  outstanding;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [2:0] cur_size;
    logic [3:0] cur_id;

    axi_burst_splitter dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_id     (cmd_id),
        .bst_valid  (bst_valid),
        .bst_ready  (bst_ready),
        .bst_addr   (bst_addr),
        .bst_len    (bst_len),
        .bst_size   (bst_size),
        .bst_id     (bst_id),
        .bst_last   (bst_last),
        .resp_done  (resp_done),
        .outstanding(outstanding),
        .busy       (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] addr;
        int          len;
        int          size;
        int          nb;
        logic [63:0] a0, a1, a2;
        int          l0, l1, l2;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic issue_cmd(input logic [63:0] a, input int l,
                             input int s, input int id);
        int n;
        @(negedge aclk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = 16'(l);
        cmd_size  = 3'(s);
        cmd_id    = 4'(id);
        cur_size  = 3'(s);
        cur_id    = 4'(id);
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk("cmd_ready", {63'b0, cmd_ready}, 64'd1);
        @(posedge aclk);
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!bst_valid && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk({nm, " valid"}, {63'b0, bst_valid}, 64'd1);
    endtask

    task automatic expect_burst(input string nm, input logic [63:0] a,
                                input int l, input bit last,
                                input bit resp);
        wait_valid(nm);
        chk({nm, " addr"}, bst_addr, a);
        chk({nm, " len"}, {56'b0, bst_len}, 64'(l));
        chk({nm, " last"}, {63'b0, bst_last}, {63'b0, last});
        chk({nm, " size"}, {61'b0, bst_size}, {61'b0, cur_size});
        chk({nm, " id"}, {60'b0, bst_id}, {60'b0, cur_id});
        @(posedge aclk);
        @(negedge aclk);
        if (resp) begin
            resp_done = 1'b1;
            @(negedge aclk);
            resp_done = 1'b0;
        end
    endtask

    task automatic pulse_resp();
        resp_done = 1'b1;
        @(negedge aclk);
        resp_done = 1'b0;
    endtask

    initial begin
        vt[0] = '{64'h1000, 15, 4, 1, 64'h1000, 0, 0, 15, 0, 0};
`ifdef AXI_BURST_SPLIT_PAGE_EN
        vt[1] = '{64'h0FC0, 15, 4, 2, 64'h0FC0, 64'h1000, 0, 3, 11, 0};
        vt[5] = '{64'hFFFF_FFFF_FFFF_FFF0, 1, 4, 2,
                  64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 0, 0, 0, 0};
        vt[6] = '{64'h0FFE, 3, 0, 2, 64'h0FFE, 64'h1000, 0, 1, 1, 0};
`else
        vt[1] = '{64'h0FC0, 15, 4, 1, 64'h0FC0, 0, 0, 15, 0, 0};
        vt[5] = '{64'hFFFF_FFFF_FFFF_FFF0, 1, 4, 1,
                  64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 1, 0, 0};
        vt[6] = '{64'h0FFE, 3, 0, 1, 64'h0FFE, 0, 0, 3, 0, 0};
`endif
        vt[2] = '{64'h0, 599, 4, 3, 64'h0, 64'h1000, 64'h2000, 255, 255, 87};
        vt[3] = '{64'h2000, 0, 4, 1, 64'h2000, 0, 0, 0, 0, 0};
        vt[4] = '{64'h1003, 3, 2, 1, 64'h1000, 0, 0, 3, 0, 0};
        vt[7] = '{64'h0, 300, 0, 2, 64'h0, 64'h100, 0, 255, 44, 0};

        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_size  = '0;
        cmd_id    = '0;
        bst_ready = 1'b1;
        resp_done = 1'b0;
        cur_size  = '0;
        cur_id    = '0;
        repeat (3) @(negedge aclk);
        chk("rst cmd_ready", {63'b0, cmd_ready}, 64'd0);
        chk("rst bst_valid", {63'b0, bst_valid}, 64'd0);
        chk("rst bst_addr", bst_addr, 64'd0);
        chk("rst outstanding", {62'b0, outstanding}, 64'd0);
        chk("rst busy", {63'b0, busy}, 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("idle cmd_ready", {63'b0, cmd_ready}, 64'd1);

        for (int i = 0; i < 8; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue_cmd(vt[i].addr, vt[i].len, vt[i].size, i + 1);
            chk({nm, " lat"}, {63'b0, bst_valid}, 64'd0);
            @(negedge aclk);
            chk({nm, " lat2"}, {63'b0, bst_valid}, 64'd1);
            for (int b = 0; b < vt[i].nb; b++) begin
                logic [63:0] ea;
                int          el;
                ea = (b == 0) ? vt[i].a0 : (b == 1) ? vt[i].a1 : vt[i].a2;
                el = (b == 0) ? vt[i].l0 : (b == 1) ? vt[i].l1 : vt[i].l2;
                expect_burst($sformatf("%s b%0d", nm, b), ea, el,
                             b == vt[i].nb - 1, 1'b1);
            end
            chk({nm, " done busy"}, {63'b0, busy}, 64'd0);
            chk({nm, " done cred"}, {62'b0, outstanding}, 64'd0);
        end

        // credit stall
        issue_cmd(64'h0, 599, 4, 9);
        expect_burst("stall b0", 64'h0, 255, 1'b0, 1'b0);
        expect_burst("stall b1", 64'h1000, 255, 1'b0, 1'b0);
        chk("stall cred2", {62'b0, outstanding}, 64'd2);
        repeat (4) @(negedge aclk);
        chk("stall held", {63'b0, bst_valid}, 64'd0);
        chk("stall busy", {63'b0, busy}, 64'd1);
        pulse_resp();
        chk("stall cred1", {62'b0, outstanding}, 64'd1);
        chk("stall v0", {63'b0, bst_valid}, 64'd0);
        @(negedge aclk);
        chk("stall v1", {63'b0, bst_valid}, 64'd1);
        expect_burst("stall b2", 64'h2000, 87, 1'b1, 1'b0);
        chk("stall cred2b", {62'b0, outstanding}, 64'd2);
        pulse_resp();
        pulse_resp();
        chk("stall drain", {62'b0, outstanding}, 64'd0);

        // backpressure and simultaneous issue + completion
        issue_cmd(64'h3000, 0, 4, 5);
        expect_burst("bp pre", 64'h3000, 0, 1'b1, 1'b0);
        chk("bp cred1", {62'b0, outstanding}, 64'd1);
        bst_ready = 1'b0;
        issue_cmd(64'h1000, 15, 4, 6);
        wait_valid("bp");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp hold v%0d", k), {63'b0, bst_valid}, 64'd1);
            chk($sformatf("bp hold a%0d", k), bst_addr, 64'h1000);
            chk($sformatf("bp hold l%0d", k), {56'b0, bst_len}, 64'd15);
            chk($sformatf("bp hold i%0d", k), {60'b0, bst_id}, 64'd6);
            @(negedge aclk);
        end
        bst_ready = 1'b1;
        resp_done = 1'b1;
        @(negedge aclk);
        resp_done = 1'b0;
        chk("bp same cred", {62'b0, outstanding}, 64'd1);
        chk("bp after v", {63'b0, bst_valid}, 64'd0);
        chk("bp after busy", {63'b0, busy}, 64'd0);
        pulse_resp();
        chk("bp drain", {62'b0, outstanding}, 64'd0);

        // reset during ISSUE
        issue_cmd(64'h0, 599, 4, 7);
        expect_burst("rst b0", 64'h0, 255, 1'b0, 1'b0);
        bst_ready = 1'b0;
        wait_valid("rst b1");
        chk("rst b1 addr", bst_addr, 64'h1000);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst valid", {63'b0, bst_valid}, 64'd0);
        chk("arst addr", bst_addr, 64'd0);
        chk("arst len", {56'b0, bst_len}, 64'd0);
        chk("arst last", {63'b0, bst_last}, 64'd0);
        chk("arst cred", {62'b0, outstanding}, 64'd0);
        chk("arst busy", {63'b0, busy}, 64'd0);
        chk("arst ready", {63'b0, cmd_ready}, 64'd0);
        @(negedge aclk);
        aresetn   = 1'b1;
        bst_ready = 1'b1;
        @(negedge aclk);
        issue_cmd(64'h2000, 0, 4, 3);
        expect_burst("post rst", 64'h2000, 0, 1'b1, 1'b1);
        chk("post rst cred", {62'b0, outstanding}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
